// File: rtl/state_flag_pkg.sv
// Shared state codes, default flag values and counter-width helper for state_flag_fsm.
package state_flag_pkg;

    localparam int ST_IDLE = 0;
    localparam int ST_RUN  = 1;
    localparam int ST_DONE = 3;

    localparam int FLAG_IDLE_DFLT    = 2;
    localparam int FLAG_RUN_DFLT     = 2;
    localparam int FLAG_DONE_DFLT    = 0;
    localparam int FLAG_DEFAULT_DFLT = 0;

    // Run counter never narrower than one bit, even for a single-cycle run.
    function automatic int cnt_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/run_cnt.sv
// Pausable run-length counter; tc flags the last unpaused cycle of a run.
module run_cnt
    import state_flag_pkg::*;
#(
    parameter int RUN_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = cnt_width(RUN_CYCLES);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(RUN_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tc = (cnt_q == TC_VAL);
    end

    // Wrap to zero on terminal count so the next run starts clean.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/state_flag_fsm.sv
// IDLE/RUN/DONE controller with Moore flag decode and undefined-state recovery.
// Define ILLEGAL_STATE_DETECT_EN to add the sticky err output.
module state_flag_fsm
    import state_flag_pkg::*;
#(
    parameter int STATE_W      = 2,
    parameter int FLAG_W       = 2,
    parameter int RUN_CYCLES   = 4,
    parameter int FLAG_IDLE    = FLAG_IDLE_DFLT,
    parameter int FLAG_RUN     = FLAG_RUN_DFLT,
    parameter int FLAG_DONE    = FLAG_DONE_DFLT,
    parameter int FLAG_DEFAULT = FLAG_DEFAULT_DFLT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               pause,
    input  logic               ack,
    output logic [STATE_W-1:0] curr_state,
    output logic [FLAG_W-1:0]  flag,
    output logic               busy,
    output logic               done
`ifdef ILLEGAL_STATE_DETECT_EN
    ,
    output logic               err
`endif
);

    localparam logic [STATE_W-1:0] S_IDLE = STATE_W'(ST_IDLE);
    localparam logic [STATE_W-1:0] S_RUN  = STATE_W'(ST_RUN);
    localparam logic [STATE_W-1:0] S_DONE = STATE_W'(ST_DONE);

    localparam logic [FLAG_W-1:0] F_IDLE = FLAG_W'(FLAG_IDLE);
    localparam logic [FLAG_W-1:0] F_RUN  = FLAG_W'(FLAG_RUN);
    localparam logic [FLAG_W-1:0] F_DONE = FLAG_W'(FLAG_DONE);
    localparam logic [FLAG_W-1:0] F_DFLT = FLAG_W'(FLAG_DEFAULT);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               cnt_clr;
    logic               cnt_en;
    logic               cnt_tc;

    // Counter is held at zero outside RUN so every run begins from a clean count.
    always_comb begin
        cnt_clr = (state_q != S_RUN);
        cnt_en  = (state_q == S_RUN) && !pause;
    end

    run_cnt #(
        .RUN_CYCLES(RUN_CYCLES)
    ) u_run_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .tc   (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN:  if (!pause && cnt_tc) state_d = S_DONE;
            S_DONE: if (ack) state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        curr_state = state_q;
        flag       = F_DFLT;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_IDLE: flag = F_IDLE;
            S_RUN: begin
                flag = F_RUN;
                busy = 1'b1;
            end
            S_DONE: begin
                flag = F_DONE;
                done = 1'b1;
            end
            default: flag = F_DFLT;
        endcase
    end

`ifdef ILLEGAL_STATE_DETECT_EN
    logic err_q;
    logic err_d;

    // Sticky: once an undefined code is seen, only reset clears the indication.
    always_comb begin
        err_d = err_q;
        if ((state_q != S_IDLE) && (state_q != S_RUN) && (state_q != S_DONE)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_state_flag_fsm.sv
// Bench for state_flag_fsm: a RUN_CYCLES=4 and a RUN_CYCLES=1 instance driven by shared stimulus.
module tb_state_flag_fsm;

    logic clk = 1'b0;
    logic rst_n, start, pause, ack;
    logic [1:0] cs   [2];
    logic [1:0] flg  [2];
    logic       busy_v [2];
    logic       done_v [2];
    logic       err_v  [2];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    bit inj    = 1'b0;

    // Expected-behaviour model: phase plus remaining unpaused run cycles.
    int m_st  [2];
    int m_rem [2];
    bit m_err [2];
    int rc    [2] = '{4, 1};

    always #5 clk = ~clk;

    state_flag_fsm #(.RUN_CYCLES(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .ack(ack),
        .curr_state(cs[0]), .flag(flg[0]), .busy(busy_v[0]), .done(done_v[0])
`ifdef ILLEGAL_STATE_DETECT_EN
        , .err(err_v[0])
`endif
    );

    state_flag_fsm #(.RUN_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .ack(ack),
        .curr_state(cs[1]), .flag(flg[1]), .busy(busy_v[1]), .done(done_v[1])
`ifdef ILLEGAL_STATE_DETECT_EN
        , .err(err_v[1])
`endif
    );

    function automatic int eff_state(input int i);
        return (i == 0 && inj) ? 2 : m_st[i];
    endfunction

    function automatic int exp_flag(input int s);
        if (s == 0) return 2;
        if (s == 1) return 2;
        if (s == 3) return 0;
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int cur;
            cur = eff_state(i);
            if (!rst_n) begin
                m_st[i]  <= 0;
                m_rem[i] <= 0;
                m_err[i] <= 1'b0;
            end else begin
                case (cur)
                    0: if (start) begin m_st[i] <= 1; m_rem[i] <= rc[i]; end
                    1: if (!pause) begin
                        if (m_rem[i] == 1) m_st[i] <= 3;
                        m_rem[i] <= m_rem[i] - 1;
                    end
                    3: if (ack) begin m_st[i] <= start ? 1 : 0; m_rem[i] <= rc[i]; end
                    default: begin m_st[i] <= 0; m_err[i] <= 1'b1; end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                int s;
                s = eff_state(i);
                chk($sformatf("dut%0d curr_state", i), int'(cs[i]), s);
                chk($sformatf("dut%0d flag", i), int'(flg[i]), exp_flag(s));
                chk($sformatf("dut%0d busy", i), int'(busy_v[i]), (s == 1) ? 1 : 0);
                chk($sformatf("dut%0d done", i), int'(done_v[i]), (s == 3) ? 1 : 0);
`ifdef ILLEGAL_STATE_DETECT_EN
                chk($sformatf("dut%0d err", i), int'(err_v[i]), int'(m_err[i]));
`endif
            end
        end
    end

    // Drive inputs for exactly one edge, leaving the bench just after that edge.
    task automatic step(input logic s, input logic a);
        start = s;
        ack   = a;
        @(posedge clk);
        #1;
        start = 1'b0;
        ack   = 1'b0;
    endtask

    // Edges from just after acceptance until done is seen on instance idx.
    task automatic measure(input int idx, input int pause_at, input int pause_len, output int lat);
        int n;
        n   = 0;
        lat = -1;
        while (n < 50) begin
            pause = (n >= pause_at) && (n < pause_at + pause_len);
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done_v[idx]) begin
                lat = n;
                break;
            end
        end
        pause = 1'b0;
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset curr_state", int'(cs[0]), 0);
        chk("reset flag", int'(flg[0]), 2);
        chk("reset done", int'(done_v[0]), 0);

        // Plain run: four busy cycles then DONE with flag 0.
        step(1'b1, 1'b0);
        @(negedge clk);
        chk("run flag", int'(flg[0]), 2);
        chk("run busy", int'(busy_v[0]), 1);
        measure(0, 100, 0, lat);
        chk("latency plain", lat, 4);
        chk("done flag", int'(flg[0]), 0);

        step(1'b0, 1'b1);
        @(negedge clk);
        chk("ack to idle", int'(cs[0]), 0);

        // Three paused cycles in the middle of the run.
        step(1'b1, 1'b0);
        measure(0, 1, 3, lat);
        chk("latency paused", lat, 7);
        repeat (2) @(negedge clk);
        chk("done holds", int'(done_v[0]), 1);

        // ack and start together in DONE go straight back to RUN.
        step(1'b1, 1'b1);
        @(negedge clk);
        chk("ack+start to run", int'(cs[0]), 1);
        measure(0, 100, 0, lat);
        chk("latency rerun", lat, 4);

        step(1'b0, 1'b1);

        // Undefined state code recovers to IDLE one edge later.
        force u_dut0.state_q = 2'b10;
        inj = 1'b1;
        @(negedge clk);
        chk("undef flag", int'(flg[0]), 0);
        #1;
        release u_dut0.state_q;
        @(posedge clk);
        #1;
        inj = 1'b0;
        @(negedge clk);
        chk("undef recover", int'(cs[0]), 0);
`ifdef ILLEGAL_STATE_DETECT_EN
        chk("err set", int'(err_v[0]), 1);
        repeat (3) @(negedge clk);
        chk("err sticky", int'(err_v[0]), 1);
`endif

        // Reset on the second RUN cycle abandons the run without a done pulse.
        step(1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrun reset state", int'(cs[0]), 0);
        chk("midrun reset flag", int'(flg[0]), 2);
        chk("midrun reset done", int'(done_v[0]), 0);
`ifdef ILLEGAL_STATE_DETECT_EN
        chk("err cleared", int'(err_v[0]), 0);
`endif
        repeat (6) @(negedge clk);
        chk("no late done", int'(done_v[0]), 0);

        // Single-cycle run on the RUN_CYCLES=1 instance.
        step(1'b1, 1'b0);
        measure(1, 100, 0, lat);
        chk("latency rc1", lat, 1);
        repeat (6) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/state_flag_fsm.md
STATE_FLAG_FSM -- requirements
Module: state_flag_fsm

Interface
REQ-001 Parameter STATE_W, default 2, state register width; SHALL be at least 2.
REQ-002 Parameter FLAG_W, default 2, flag output width.
REQ-003 Parameter RUN_CYCLES, default 4, number of unpaused cycles spent in RUN; SHALL be at least 1.
REQ-004 Parameter FLAG_IDLE, default 2, flag value in IDLE.
REQ-005 Parameter FLAG_RUN, default 2, flag value in RUN.
REQ-006 Parameter FLAG_DONE, default 0, flag value in DONE.
REQ-007 Parameter FLAG_DEFAULT, default 0, flag value for any undefined state code.
REQ-008 clk  input  1  single clock; all state updates on the rising edge.
REQ-009 rst_n  input  1  reset, synchronous, active-low.
REQ-010 start  input  1  request to begin a run.
REQ-011 pause  input  1  freezes the RUN counter while high.
REQ-012 ack  input  1  acknowledges DONE.
REQ-013 curr_state  output  STATE_W  current state register.
REQ-014 flag  output  FLAG_W  Moore decode of curr_state.
REQ-015 busy  output  1  high when curr_state is RUN.
REQ-016 done  output  1  high when curr_state is DONE.
REQ-017 err  output  1  sticky illegal-state indicator; present only with ILLEGAL_STATE_DETECT_EN.

Function
REQ-018 State codes SHALL be IDLE=0, RUN=1, DONE=3; code 2 and every code above 3 SHALL be undefined.
REQ-019 flag SHALL be a combinational decode of curr_state with a default assignment of FLAG_DEFAULT before the case, so no latch is inferred.
REQ-020 IDLE: start=1 at an edge -> RUN at that edge, run counter cleared to 0; start=0 -> stay in IDLE.
REQ-021 RUN: pause=1 -> counter and state hold; pause=0 and counter<RUN_CYCLES-1 -> counter increments.
REQ-022 RUN: pause=0 and counter==RUN_CYCLES-1 -> DONE at that edge, counter cleared to 0.
REQ-023 start in RUN SHALL be ignored; there is no abort except reset.
REQ-024 DONE: state holds until ack=1; ack=1,start=0 -> IDLE; ack=1,start=1 in the same cycle -> RUN directly, counter 0.
REQ-025 Any undefined code in curr_state SHALL move to IDLE on the next edge; flag reads FLAG_DEFAULT for that one cycle.
REQ-026 The counter SHALL be max(1,$clog2(RUN_CYCLES)) bits wide; with RUN_CYCLES=1, RUN SHALL last exactly one unpaused cycle.
REQ-027 The time from start acceptance to done=1 SHALL be RUN_CYCLES plus the number of paused RUN cycles.

Reset
REQ-028 rst_n=0 at an edge SHALL force curr_state=IDLE, counter=0, busy=0, done=0 and err=0, so flag=FLAG_IDLE, regardless of other inputs.
REQ-029 Reset in RUN or DONE SHALL abandon the run with no done pulse.

Configuration
REQ-030 Macro ILLEGAL_STATE_DETECT_EN defined: err SHALL set on the edge after an undefined code is observed, and clear only on reset.
REQ-031 Macro undefined: the err port and its logic SHALL be absent; recovery per REQ-025 is unchanged.

Structure
REQ-032 Package state_flag_pkg SHALL hold the state code localparams (IDLE, RUN, DONE) and the default flag constants.
REQ-033 Sub-module run_cnt SHALL hold the pausable counter and its terminal-count output.

Verification
REQ-034 Defaults: reset, then start=1 for 1 cycle -> busy=1 and flag=2 for 4 cycles, then done=1 and flag=0.
REQ-035 pause=1 for 3 cycles mid-RUN -> done asserts 7 cycles after start acceptance.
REQ-036 In DONE, ack=1 and start=1 together -> curr_state=1 next cycle, then 4 cycles to done.
REQ-037 Force curr_state=2 -> flag=0 that cycle, curr_state=0 next cycle; with the macro, err=1 and stays 1 until rst_n=0.
REQ-038 rst_n=0 on RUN cycle 2 -> curr_state=0, flag=2, no done pulse; RUN_CYCLES=1 -> done the cycle after start.
